// File: rtl/pixel_gen_pkg.sv
// Shared types and constants for the pixel_gen RGB test-pattern source.
package pixel_gen_pkg;

    typedef logic [23:0] pixel_t;  // {R, G, B}

    typedef enum logic [1:0] {
        REG_BLUE   = 2'd0,
        REG_FRAMES = 2'd1,
        REG_ID     = 2'd2,
        REG_RSVD   = 2'd3
    } reg_idx_e;

    localparam logic [31:0] PIXEL_GEN_ID = 32'h5049_5847;
    localparam logic [3:0]  TKEEP_ALL    = 4'hF;

    function automatic pixel_t make_pixel(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_gen_if.sv
// Bus bundles for pixel_gen: AXI4-Stream video output and AXI4-Lite control port.
interface pixel_gen_axis_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

interface pixel_gen_axil_if;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
                    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
    modport slave  (input awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
                    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/pixel_gen_axil_regs.sv
// AXI4-Lite slave for pixel_gen; the BLUE/FRAMES/ID bank exists only with PIXEL_GEN_REGS_EN,
// otherwise handshakes complete identically with zero read data.
module pixel_gen_axil_regs
    import pixel_gen_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    pixel_gen_axil_if.slave  axil,
    input  logic             frame_done_i,
    output logic [7:0]       blue_o
);

    logic        wr_fire, rd_fire;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_value;

    // Ready is a single-cycle pulse: the pending response blocks a second accept.
    assign wr_fire = rst_ni && axil.awvalid && axil.wvalid && !bvalid_q;
    assign rd_fire = rst_ni && axil.arvalid && !rvalid_q;

    assign axil.awready = wr_fire;
    assign axil.wready  = wr_fire;
    assign axil.arready = rd_fire;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = 2'b00;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = 2'b00;

    always_comb begin
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (bvalid_q && axil.bready) bvalid_d = 1'b0;
        if (wr_fire)                 bvalid_d = 1'b1;
        if (rvalid_q && axil.rready) rvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_value;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef PIXEL_GEN_REGS_EN
    logic [31:0] blue_q, frames_q;
    reg_idx_e    wr_idx, rd_idx;
    logic        unused_ok;

    assign wr_idx = reg_idx_e'(axil.awaddr[3:2]);
    assign rd_idx = reg_idx_e'(axil.araddr[3:2]);

    always_comb begin
        rd_value = '0;
        case (rd_idx)
            REG_BLUE:   rd_value = blue_q;
            REG_FRAMES: rd_value = frames_q;
            REG_ID:     rd_value = PIXEL_GEN_ID;
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            blue_q   <= '0;
            frames_q <= '0;
        end else begin
            if (wr_fire && (wr_idx == REG_BLUE)) blue_q <= axil.wdata;
            if (frame_done_i)                    frames_q <= frames_q + 32'd1;
        end
    end

    assign blue_o    = blue_q[7:0];
    assign unused_ok = ^{axil.awaddr[7:4], axil.awaddr[1:0], axil.araddr[7:4],
                         axil.araddr[1:0], blue_q[31:8]};
`else
    logic unused_ok;

    assign rd_value  = '0;
    assign blue_o    = '0;
    assign unused_ok = ^{frame_done_i, axil.awaddr, axil.araddr, axil.wdata};
`endif

endmodule

// File: rtl/pixel_gen.sv
// RGB test-pattern source: packs 24-bit pixels into a 32-bit AXI4-Stream, AXI4-Lite control.
// Optional register bank enabled by defining PIXEL_GEN_REGS_EN.
module pixel_gen
    import pixel_gen_pkg::*;
#(
    parameter int unsigned X_PIXELS = 200,
    parameter int unsigned Y_LINES  = 200
) (
    input  logic              out_stream_aclk,
    input  logic              axi_resetn,
    pixel_gen_axis_if.master  out_stream,
    pixel_gen_axil_if.slave   s_axi_lite
);

    localparam int unsigned WORDS   = X_PIXELS * 3 / 4;
    localparam logic [15:0] LAST_WX = 16'(WORDS - 1);
    localparam logic [15:0] LAST_Y  = 16'(Y_LINES - 1);

    typedef enum logic [1:0] {PH_W0, PH_W1, PH_W2} phase_e;

    phase_e      phase_q, phase_d;
    logic [15:0] wx_q, wx_d, gx_q, gx_d, y_q, y_d;
    logic        tvalid_q, tuser_q, tuser_d, tlast_q, tlast_d;
    logic [31:0] tdata_q, tdata_d;
    logic [7:0]  blue_frame_q, blue_cur, blue_reg, r_base;
    logic        hs, load, frame_done;
    pixel_t      p0, p1, p2, p3;

    // Counters track the word currently presented; the output register is refilled
    // from the advanced counters whenever it is empty or being consumed.
    assign hs   = tvalid_q && out_stream.tready;
    assign load = !tvalid_q || out_stream.tready;

    always_comb begin
        phase_d    = phase_q;
        wx_d       = wx_q;
        gx_d       = gx_q;
        y_d        = y_q;
        frame_done = 1'b0;
        if (hs) begin
            if (wx_q == LAST_WX) begin
                wx_d    = '0;
                gx_d    = '0;
                phase_d = PH_W0;
                if (y_q == LAST_Y) begin
                    y_d        = '0;
                    frame_done = 1'b1;
                end else begin
                    y_d = y_q + 16'd1;
                end
            end else begin
                wx_d = wx_q + 16'd1;
                case (phase_q)
                    PH_W0:   phase_d = PH_W1;
                    PH_W1:   phase_d = PH_W2;
                    default: begin
                        phase_d = PH_W0;
                        gx_d    = gx_q + 16'd1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        tuser_d  = (wx_d == '0) && (y_d == '0);
        tlast_d  = (wx_d == LAST_WX);
        // BLUE is captured with the SOF word and reused for the rest of the frame.
        blue_cur = tuser_d ? blue_reg : blue_frame_q;
        r_base   = 8'(gx_d << 2);
        p0       = make_pixel(r_base,         8'(y_d), blue_cur);
        p1       = make_pixel(r_base + 8'd1,  8'(y_d), blue_cur);
        p2       = make_pixel(r_base + 8'd2,  8'(y_d), blue_cur);
        p3       = make_pixel(r_base + 8'd3,  8'(y_d), blue_cur);
        case (phase_d)
            PH_W0:   tdata_d = {p1[7:0], p0};
            PH_W1:   tdata_d = {p2[15:0], p1[23:8]};
            default: tdata_d = {p3, p2[23:16]};
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!axi_resetn) begin
            phase_q      <= PH_W0;
            wx_q         <= '0;
            gx_q         <= '0;
            y_q          <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            blue_frame_q <= '0;
        end else begin
            phase_q <= phase_d;
            wx_q    <= wx_d;
            gx_q    <= gx_d;
            y_q     <= y_d;
            if (load) begin
                tvalid_q     <= 1'b1;
                tdata_q      <= tdata_d;
                tuser_q      <= tuser_d;
                tlast_q      <= tlast_d;
                blue_frame_q <= blue_cur;
            end
        end
    end

    assign out_stream.tdata  = tdata_q;
    assign out_stream.tkeep  = TKEEP_ALL;
    assign out_stream.tlast  = tlast_q;
    assign out_stream.tuser  = tuser_q;
    assign out_stream.tvalid = tvalid_q;

    pixel_gen_axil_regs u_regs (
        .clk_i        (out_stream_aclk),
        .rst_ni       (axi_resetn),
        .axil         (s_axi_lite),
        .frame_done_i (frame_done),
        .blue_o       (blue_reg)
    );

endmodule

// File: tb/tb_pixel_gen.sv
// Self-checking bench for pixel_gen: line byte-stream reference model, random back-pressure,
// mid-frame reset and AXI-Lite register accesses (register expectations follow PIXEL_GEN_REGS_EN).
module tb_pixel_gen;

    localparam int unsigned XP  = 200;
    localparam int unsigned YL  = 200;
    localparam int unsigned WPL = XP * 3 / 4;
`ifdef PIXEL_GEN_REGS_EN
    localparam bit REGS = 1'b1;
`else
    localparam bit REGS = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pixel_gen_axis_if out_stream();
    pixel_gen_axil_if s_axi_lite();

    pixel_gen #(.X_PIXELS(XP), .Y_LINES(YL)) dut (
        .out_stream_aclk (clk),
        .axi_resetn      (resetn),
        .out_stream      (out_stream),
        .s_axi_lite      (s_axi_lite)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Each pixel contributes bytes B, G(=line), R(=x) to the line; words take 4 bytes LSB first.
    function automatic logic [31:0] exp_word(input int unsigned w, input int unsigned line,
                                             input logic [7:0] b);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int unsigned j = 4 * w + i;
            logic [7:0] byt;
            case (j % 3)
                0:       byt = b;
                1:       byt = 8'(line);
                default: byt = 8'(j / 3);
            endcase
            r[8*i +: 8] = byt;
        end
        return r;
    endfunction

    int unsigned m_w = 0, m_y = 0, m_frames = 0, m_words = 0, m_sof = 0, m_eol = 0;
    logic [7:0]  tb_blue = '0;
    logic [7:0]  m_blue  = '0;
    bit          rand_ready = 1'b0, started = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_user = 1'b0, prev_last = 1'b0;

    initial begin
        out_stream.tready = 1'b1;
        forever begin
            @(negedge clk);
            out_stream.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!resetn) begin
                m_w = 0; m_y = 0; m_frames = 0;
                started = 1'b0; prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_data", out_stream.tdata, prev_data);
                    check_eq("stall_user", 32'(out_stream.tuser), 32'(prev_user));
                    check_eq("stall_last", 32'(out_stream.tlast), 32'(prev_last));
                end
                if (started) check_eq("valid_held", 32'(out_stream.tvalid), 1);
                if (out_stream.tvalid) started = 1'b1;
                if (out_stream.tvalid && out_stream.tready) begin
                    if (m_w == 0 && m_y == 0) m_blue = tb_blue;
                    check_eq("tdata", out_stream.tdata, exp_word(m_w, m_y, m_blue));
                    check_eq("tuser", 32'(out_stream.tuser), 32'(m_w == 0 && m_y == 0));
                    check_eq("tlast", 32'(out_stream.tlast), 32'(m_w == WPL - 1));
                    check_eq("tkeep", 32'(out_stream.tkeep), 32'hF);
                    m_words++;
                    if (out_stream.tuser) m_sof++;
                    if (out_stream.tlast) m_eol++;
                    m_w++;
                    if (m_w == WPL) begin
                        m_w = 0;
                        m_y++;
                        if (m_y == YL) begin
                            m_y = 0;
                            m_frames++;
                        end
                    end
                end
                prev_stall = out_stream.tvalid && !out_stream.tready;
                prev_data  = out_stream.tdata;
                prev_user  = out_stream.tuser;
                prev_last  = out_stream.tlast;
            end
        end
    end

    task automatic wait_pos(input int unsigned fr, input int unsigned ln, input int unsigned budget);
        int unsigned n = 0;
        while (!(m_frames > fr || (m_frames == fr && m_y >= ln)) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq("wait_pos_timeout", 32'(n < budget), 1);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_stream.tvalid && n < 4);
        check_eq({tag, "_valid"}, 32'(out_stream.tvalid), 1);
        check_eq({tag, "_sof"}, 32'(out_stream.tuser), 1);
        check_eq({tag, "_data"}, out_stream.tdata, exp_word(0, 0, 8'h00));
        #1;
    endtask

    task automatic axil_write(input logic [7:0] a, input logic [31:0] d, input string tag);
        int unsigned n = 0;
        s_axi_lite.awaddr = a; s_axi_lite.wdata = d;
        s_axi_lite.awvalid = 1'b1; s_axi_lite.wvalid = 1'b1;
        #1;
        while (!(s_axi_lite.awready && s_axi_lite.wready) && n < 8) begin
            @(posedge clk); #3;
            n++;
        end
        check_eq({tag, "_awready"}, 32'(s_axi_lite.awready && s_axi_lite.wready), 1);
        @(posedge clk); #2;
        s_axi_lite.awvalid = 1'b0; s_axi_lite.wvalid = 1'b0;
        if (REGS && a[3:2] == 2'd0) tb_blue = d[7:0];
        check_eq({tag, "_bvalid"}, 32'(s_axi_lite.bvalid), 1);
        check_eq({tag, "_bresp"}, 32'(s_axi_lite.bresp), 0);
        check_eq({tag, "_awpulse"}, 32'(s_axi_lite.awready), 0);
        s_axi_lite.bready = 1'b1;
        @(posedge clk); #2;
        s_axi_lite.bready = 1'b0;
        check_eq({tag, "_bdone"}, 32'(s_axi_lite.bvalid), 0);
    endtask

    task automatic axil_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        int unsigned n = 0;
        s_axi_lite.araddr = a; s_axi_lite.arvalid = 1'b1;
        #1;
        while (!s_axi_lite.arready && n < 8) begin
            @(posedge clk); #3;
            n++;
        end
        check_eq({tag, "_arready"}, 32'(s_axi_lite.arready), 1);
        @(posedge clk); #2;
        s_axi_lite.arvalid = 1'b0;
        check_eq({tag, "_rvalid"}, 32'(s_axi_lite.rvalid), 1);
        check_eq({tag, "_rdata"}, s_axi_lite.rdata, exp);
        check_eq({tag, "_rresp"}, 32'(s_axi_lite.rresp), 0);
        s_axi_lite.rready = 1'b1;
        @(posedge clk); #2;
        s_axi_lite.rready = 1'b0;
        check_eq({tag, "_rdone"}, 32'(s_axi_lite.rvalid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, 32'(out_stream.tvalid), 0);
        check_eq({tag, "_tuser"}, 32'(out_stream.tuser), 0);
        check_eq({tag, "_tlast"}, 32'(out_stream.tlast), 0);
        check_eq({tag, "_tdata"}, out_stream.tdata, 0);
        check_eq({tag, "_bvalid"}, 32'(s_axi_lite.bvalid), 0);
        check_eq({tag, "_rvalid"}, 32'(s_axi_lite.rvalid), 0);
        check_eq({tag, "_rdata"}, s_axi_lite.rdata, 0);
        check_eq({tag, "_readies"},
                 32'({s_axi_lite.awready, s_axi_lite.wready, s_axi_lite.arready}), 0);
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        s_axi_lite.awaddr = '0; s_axi_lite.awvalid = 1'b0;
        s_axi_lite.wdata  = '0; s_axi_lite.wvalid  = 1'b0;
        s_axi_lite.bready = 1'b0;
        s_axi_lite.araddr = '0; s_axi_lite.arvalid = 1'b0;
        s_axi_lite.rready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        wait_valid("start");

        axil_read(8'h08, REGS ? 32'h5049_5847 : 32'h0, "rd_id");
        axil_read(8'h0C, 32'h0, "rd_rsvd");
        axil_read(8'h00, 32'h0, "rd_blue_rst");
        wait_pos(0, 5, 2000);
        axil_write(8'h00, 32'h0000_00A5, "wr_blue");
        axil_read(8'h00, REGS ? 32'hA5 : 32'h0, "rd_blue");
        axil_write(8'h04, 32'hDEAD_BEEF, "wr_frames");
        axil_write(8'h08, 32'h1234_5678, "wr_id");
        axil_read(8'h04, 32'h0, "rd_frames0");
        axil_read(8'h08, REGS ? 32'h5049_5847 : 32'h0, "rd_id2");

        wait_pos(1, 10, 40000);
        // Write BLUE and read ID in the same cycle.
        s_axi_lite.awaddr = 8'h00; s_axi_lite.wdata = 32'h0000_005A;
        s_axi_lite.awvalid = 1'b1; s_axi_lite.wvalid = 1'b1;
        s_axi_lite.araddr = 8'h08; s_axi_lite.arvalid = 1'b1;
        #1;
        check_eq("dual_ready", 32'({s_axi_lite.awready, s_axi_lite.wready, s_axi_lite.arready}), 7);
        @(posedge clk); #2;
        s_axi_lite.awvalid = 1'b0; s_axi_lite.wvalid = 1'b0; s_axi_lite.arvalid = 1'b0;
        if (REGS) tb_blue = 8'h5A;
        check_eq("dual_resp", 32'({s_axi_lite.bvalid, s_axi_lite.rvalid}), 3);
        check_eq("dual_rdata", s_axi_lite.rdata, REGS ? 32'h5049_5847 : 32'h0);
        s_axi_lite.bready = 1'b1; s_axi_lite.rready = 1'b1;
        @(posedge clk); #2;
        s_axi_lite.bready = 1'b0; s_axi_lite.rready = 1'b0;
        axil_read(8'h00, REGS ? 32'h5A : 32'h0, "rd_blue2");

        wait_pos(2, 0, 40000);
        check_eq("words_2frames", m_words, 60000);
        check_eq("sof_2frames", m_sof, 2);
        check_eq("eol_2frames", m_eol, 400);
        repeat (2) @(posedge clk);
        #2;
        axil_read(8'h04, REGS ? 32'd2 : 32'h0, "rd_frames2");

        rand_ready = 1'b1;
        wait_pos(2, 57, 40000);
        resetn  = 1'b0;
        tb_blue = 8'h00;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_valid("restart");
        axil_read(8'h04, 32'h0, "rd_frames_rst");
        axil_read(8'h00, 32'h0, "rd_blue_rst2");
        wait_pos(0, 2, 4000);
        check_eq("restart_line", 32'(m_y >= 2 && m_frames == 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
